// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage piecewise-linear sigmoid/tanh approximation with valid/ready flow
// control and a counter of samples landing in the saturated segment.
module sigmoid_pwl_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [15:0]       sat_cnt
);

  // Handshake: a word moves across a boundary on a rising edge only when the
  // sender's valid and the receiver's ready are both high; a stage is ready
  // when it is empty or its own content leaves on that same edge.

  localparam int ONE_I  = 1 << FRAC_W;
  localparam int HALF_I = 1 << (FRAC_W - 1);
  localparam int C2_I   = 5 << (FRAC_W - 3);
  localparam int C3_I   = 27 << (FRAC_W - 5);
  localparam int T2_I   = 19 << (FRAC_W - 3);
  localparam int T5_I   = 5 << FRAC_W;

  localparam logic [DATA_W:0] ONE  = ONE_I[DATA_W:0];
  localparam logic [DATA_W:0] HALF = HALF_I[DATA_W:0];
  localparam logic [DATA_W:0] C2   = C2_I[DATA_W:0];
  localparam logic [DATA_W:0] C3   = C3_I[DATA_W:0];
  localparam logic [DATA_W:0] T2   = T2_I[DATA_W:0];
  localparam logic [DATA_W:0] T5   = T5_I[DATA_W:0];

  localparam logic [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};

  logic              v1, v2, v3;
  logic              r1, r2, r3;
  logic              s1_sign, s1_mode;
  logic [DATA_W-1:0] s1_a;
  logic              s2_sign, s2_mode;
  logic [DATA_W:0]   s2_p;
  logic [DATA_W-1:0] out_r;

  logic              ovf;
  logic [DATA_W-1:0] xp;
  logic [DATA_W-1:0] a_in;
  logic              sat_in;
  logic [DATA_W:0]   a_ext;
  logic [DATA_W:0]   p_nx;
  logic [DATA_W:0]   q;
  logic [DATA_W:0]   y_w;
  logic [DATA_W-1:0] y_nx;

  assign r3        = !v3 || out_ready;
  assign r2        = !v2 || r3;
  assign r1        = !v1 || r2;
  assign in_ready  = r1;
  assign out_valid = v3;
  assign out_data  = out_r;

  // S1: optional doubling for tanh, then sign/magnitude split
  always_comb begin
    ovf  = in_mode && (in_data[DATA_W-1] != in_data[DATA_W-2]);
    xp   = in_data;
    a_in = '0;
    if (in_mode) begin
      if (ovf) xp = in_data[DATA_W-1] ? MIN_D : MAX_D;
      else     xp = {in_data[DATA_W-2:0], 1'b0};
    end
    if (!xp[DATA_W-1])   a_in = xp;
    else if (xp == MIN_D) a_in = MAX_D;
    else                  a_in = -xp;
    sat_in = {1'b0, a_in} >= T5;
  end

  // S2: segment select on |x'|
  always_comb begin
    a_ext = {1'b0, s1_a};
    p_nx  = ONE;
    if (a_ext < ONE)     p_nx = (a_ext >> 2) + HALF;
    else if (a_ext < T2) p_nx = (a_ext >> 3) + C2;
    else if (a_ext < T5) p_nx = (a_ext >> 5) + C3;
  end

  // S3: reflect for negative inputs, map to tanh, clamp on narrowing
  always_comb begin
    q    = s2_sign ? (ONE - s2_p) : s2_p;
    y_w  = s2_mode ? ((q << 1) - ONE) : q;
    y_nx = y_w[DATA_W-1:0];
    if (y_w[DATA_W] != y_w[DATA_W-1]) y_nx = y_w[DATA_W] ? MIN_D : MAX_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_sign <= 1'b0;
      s1_mode <= 1'b0;
      s1_a    <= '0;
      s2_sign <= 1'b0;
      s2_mode <= 1'b0;
      s2_p    <= '0;
      out_r   <= '0;
    end else begin
      if (r1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sign <= xp[DATA_W-1];
          s1_mode <= in_mode;
          s1_a    <= a_in;
        end
      end
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign <= s1_sign;
          s2_mode <= s1_mode;
          s2_p    <= p_nx;
        end
      end
      if (r3) begin
        v3 <= v2;
        if (v2) out_r <= y_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (in_valid && r1 && sat_in && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Directed vector bench for sigmoid_pwl_pipe: table of hand-computed results,
// an output scoreboard, and sequences for backpressure, counter clear and reset.
module tb_sigmoid_pwl_pipe;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int NV = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          cnt_clr = 1'b0;
  logic [15:0]   sat_cnt;

  sigmoid_pwl_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          mode;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          sat;
  } vec_t;
  vec_t tbl[NV];

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  bit            lat_chk = 1'b0;
  bit            rdy_chk = 1'b0;
  bit            hold_pend = 1'b0;
  bit            bp_done = 1'b0;
  logic [DW-1:0] hold_val = '0;
  int            exp_sat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one sample; call at posedge+#1, returns at posedge+#1 after acceptance.
  task automatic send(input logic m, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(y);
      acc_q.push_back(cyc);
    end else begin
      check("accept_timeout", 32'(ok), 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  // Output monitor: transfers happen on the posedge that follows this negedge.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int a;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (rdy_chk) check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !out_ready)));
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_val));
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_out: got 0x%0h with nothing expected (cycle %0d)", out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
          if (lat_chk) check("latency", cyc - a, 2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 16'h0080, 1'b0};
    tbl[1]  = '{1'b0, 16'h0100, 16'h00C0, 1'b0};
    tbl[2]  = '{1'b0, 16'hFF00, 16'h0040, 1'b0};
    tbl[3]  = '{1'b0, 16'h0260, 16'h00EB, 1'b0};
    tbl[4]  = '{1'b0, 16'h0600, 16'h0100, 1'b1};
    tbl[5]  = '{1'b0, 16'hFA00, 16'h0000, 1'b1};
    tbl[6]  = '{1'b0, 16'h7FFF, 16'h0100, 1'b1};
    tbl[7]  = '{1'b0, 16'h8000, 16'h0000, 1'b1};
    tbl[8]  = '{1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 16'h0080, 16'h0080, 1'b0};
    tbl[10] = '{1'b1, 16'hFF80, 16'hFF80, 1'b0};
    tbl[11] = '{1'b1, 16'h4000, 16'h0100, 1'b1};
    tbl[12] = '{1'b0, 16'h04FF, 16'h00FF, 1'b0};
    tbl[13] = '{1'b0, 16'h0500, 16'h0100, 1'b1};
    tbl[14] = '{1'b0, 16'h00FF, 16'h00BF, 1'b0};
    tbl[15] = '{1'b0, 16'h025F, 16'h00EB, 1'b0};
    tbl[16] = '{1'b0, 16'hFFFF, 16'h0080, 1'b0};
    tbl[17] = '{1'b1, 16'h8000, 16'hFF00, 1'b1};
    tbl[18] = '{1'b1, 16'hC000, 16'hFF00, 1'b1};
    tbl[19] = '{1'b1, 16'h3FFF, 16'h0100, 1'b1};
    tbl[20] = '{1'b0, 16'h0180, 16'h00D0, 1'b0};
    tbl[21] = '{1'b0, 16'h0380, 16'h00F4, 1'b0};
    tbl[22] = '{1'b1, 16'h0100, 16'h00C0, 1'b0};
    tbl[23] = '{1'b0, 16'hFF7F, 16'h0060, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table, back-to-back with out_ready high; first send starts at release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].mode, tbl[i].x, tbl[i].y);
      if (tbl[i].sat) exp_sat++;
    end
    drain();
    lat_chk = 1'b0;
    check("sat_cnt_table", 32'(sat_cnt), 32'(exp_sat));

    // Backpressure with pseudo-random out_ready
    rdy_chk = 1'b1;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(tbl[i].mode, tbl[i].x, tbl[i].y);
          if (tbl[i].sat) exp_sat++;
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    repeat (6) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    drain();
    rdy_chk = 1'b0;
    check("sat_cnt_bp", 32'(sat_cnt), 32'(exp_sat));

    // Clear wins over a simultaneous saturating accept
    cnt_clr = 1'b1;
    send(1'b0, 16'h7FFF, 16'h0100);
    cnt_clr = 1'b0;
    check("sat_cnt_clr", 32'(sat_cnt), 32'd0);
    send(1'b0, 16'h0600, 16'h0100);
    check("sat_cnt_after_clr", 32'(sat_cnt), 32'd1);
    drain();

    // Reset with three samples in flight and output stalled
    out_ready = 1'b0;
    send(1'b0, 16'h0600, 16'h0100);
    send(1'b1, 16'h4000, 16'h0100);
    send(1'b0, 16'hFA00, 16'h0000);
    check("sat_cnt_pre_rst", 32'(sat_cnt), 32'd4);
    check("in_ready_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_data", 32'(out_data), 32'd0);

    // One more sample after the reset to show the pipe restarts cleanly
    send(1'b0, 16'h0100, 16'h00C0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
